// File: rtl/cu_sequencer_pkg.sv
// Shared types for the CU request sequencer: CU opcode, power mode and flag
// types, the sequencer FSM state, and the per-(op, pmode) latency lookup.
package cu_sequencer_pkg;

  // CU opcode. Only MUL is distinguished for latency; every other
  // enumerator takes the ADD latency.
  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MUL  = 2'd2,
    PASS = 2'd3
  } operation_t;

  // CU power mode.
  typedef enum logic {
    NORMAL = 1'b0,
    LP     = 1'b1
  } powermode_t;

  // CU status flags. The sequencer carries these opaquely and never looks
  // inside.
  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAKE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } cu_seq_state_t;

  // Latency counter width; covers the legal latency range 1..15.
  localparam int LAT_W = 4;

  // Number of CU cycles needed for one operation in the given power mode.
  function automatic logic [LAT_W-1:0] cu_lat(
    input operation_t op,
    input powermode_t pmode,
    input int         lat_add_normal,
    input int         lat_mul_normal,
    input int         lat_add_lp,
    input int         lat_mul_lp
  );
    int lat;
    if (op == MUL) begin
      lat = (pmode == LP) ? lat_mul_lp : lat_mul_normal;
    end else begin
      lat = (pmode == LP) ? lat_add_lp : lat_add_normal;
    end
    return LAT_W'(lat);
  endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Request/response handshake bundle between a requester and cu_sequencer.
// The master side issues requests and consumes responses; the slave side is
// the sequencer.
interface cu_sequencer_if
  import cu_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  // Request channel
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_op1;
  logic [WIDTH-1:0] req_op2;
  operation_t       req_op;
  powermode_t       req_pmode;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  flags_t           rsp_fls;

  modport master (
    output req_valid,
    output req_op1,
    output req_op2,
    output req_op,
    output req_pmode,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_fls,
    output rsp_ready
  );

  modport slave (
    input  req_valid,
    input  req_op1,
    input  req_op2,
    input  req_op,
    input  req_pmode,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_fls,
    input  rsp_ready
  );

endinterface

// File: rtl/cu_sequencer.sv
// Request-side front end for the CU datapath. Accepts one operation at a
// time, drives and holds the CU inputs, waits a fixed latency that depends
// on (op, pmode), captures result/flags and returns them on the response
// channel. Also puts the CU to sleep after a programmable idle period and
// inserts one wake cycle when a request arrives while asleep.
module cu_sequencer
  import cu_sequencer_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int LAT_ADD_NORMAL = 1,
  parameter int LAT_MUL_NORMAL = 2,
  parameter int LAT_ADD_LP     = 2,
  parameter int LAT_MUL_LP     = 4,
  parameter int IDLE_SLEEP     = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  cu_sequencer_if.slave    bus,

  output logic [WIDTH-1:0] cu_op1,
  output logic [WIDTH-1:0] cu_op2,
  output operation_t       cu_op,
  output powermode_t       cu_pmode,
  output logic             cu_sleep,
  input  logic [WIDTH-1:0] cu_result,
  input  flags_t           cu_fls
);

  // Idle counter sized to hold IDLE_SLEEP; a one-bit counter that never
  // leaves zero when sleep is disabled.
  localparam int              IDLE_W    = (IDLE_SLEEP > 0) ? $clog2(IDLE_SLEEP + 1) : 1;
  localparam logic [IDLE_W-1:0] SLEEP_CNT = IDLE_W'(IDLE_SLEEP);
  localparam logic            SLEEP_EN  = (IDLE_SLEEP != 0);

  cu_seq_state_t     state;
  cu_seq_state_t     state_next;
  logic [LAT_W-1:0]  lat_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_cnt_next;

  logic accept;
  logic capture;
  logic release_rsp;

  // Handshake qualifiers. The capture test uses <= 1 so a zero latency
  // (outside the legal range) still completes rather than wrapping.
  assign accept      = (state == IDLE) && bus.req_valid;
  assign capture     = (state == WAIT) && (lat_cnt <= LAT_W'(1));
  assign release_rsp = (state == RESP) && bus.rsp_ready;

  // Requests are taken only in IDLE; no overlap with an outstanding response.
  assign bus.req_ready = (state == IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop in
  // the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = cu_sleep ? WAKE : WAIT;
        end
      end
      WAKE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (capture) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latency counter: loaded on accept, held through WAKE, counts down in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (accept) begin
      lat_cnt <= cu_lat(bus.req_op, bus.req_pmode,
                        LAT_ADD_NORMAL, LAT_MUL_NORMAL, LAT_ADD_LP, LAT_MUL_LP);
    end else if ((state == WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // CU operand registers: change only on accept so the CU inputs do not
  // toggle while idle or asleep.
  // NOTE: these are reset to defined values so the CU never sees X inputs
  // coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cu_op1   <= '0;
      cu_op2   <= '0;
      cu_op    <= ADD;
      cu_pmode <= NORMAL;
    end else if (accept) begin
      cu_op1   <= bus.req_op1;
      cu_op2   <= bus.req_op2;
      cu_op    <= bus.req_op;
      cu_pmode <= bus.req_pmode;
    end
  end

  // Response data: sampled from the CU once, on the capture edge, then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_result <= '0;
      bus.rsp_fls    <= '0;
    end else if (capture) begin
      bus.rsp_result <= cu_result;
      bus.rsp_fls    <= cu_fls;
    end
  end

  // Response valid: raised with the capture, dropped on the consuming edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
    end else if (capture) begin
      bus.rsp_valid <= 1'b1;
    end else if (release_rsp) begin
      bus.rsp_valid <= 1'b0;
    end
  end

  // Idle counter next value: counts IDLE cycles without an accept and
  // saturates at IDLE_SLEEP; anything else clears it.
  always_comb begin
    idle_cnt_next = '0;
    if ((state == IDLE) && !accept) begin
      idle_cnt_next = (idle_cnt == SLEEP_CNT) ? idle_cnt : idle_cnt + 1'b1;
    end
  end

  // Idle counter and registered sleep request. Sleep rises together with the
  // counter reaching IDLE_SLEEP and clears on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      cu_sleep <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_next;
      cu_sleep <= SLEEP_EN && (idle_cnt_next == SLEEP_CNT);
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer. A small behavioural CU sits beside the
// DUT, as it would at the parent level; expected values are hand-computed.
module tb_cu_sequencer;
  import cu_sequencer_pkg::*;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] cu_op1;
  logic [WIDTH-1:0] cu_op2;
  operation_t       cu_op;
  powermode_t       cu_pmode;
  logic             cu_sleep;
  logic [WIDTH-1:0] cu_result;
  flags_t           cu_fls;
  logic             cu_corrupt;

  int checks = 0;
  int errors = 0;

  cu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cu_sequencer #(
    .WIDTH         (WIDTH),
    .LAT_ADD_NORMAL(1),
    .LAT_MUL_NORMAL(2),
    .LAT_ADD_LP    (2),
    .LAT_MUL_LP    (4),
    .IDLE_SLEEP    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cu_op1   (cu_op1),
    .cu_op2   (cu_op2),
    .cu_op    (cu_op),
    .cu_pmode (cu_pmode),
    .cu_sleep (cu_sleep),
    .cu_result(cu_result),
    .cu_fls   (cu_fls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CU. cu_corrupt forces a junk result so any re-sampling of
  // the CU after capture shows up in rsp_*.
  logic [16:0] sum17;
  logic [16:0] dif17;
  logic [31:0] prod32;
  logic [15:0] res;
  flags_t      fl;
  always_comb begin
    sum17  = {1'b0, cu_op1} + {1'b0, cu_op2};
    dif17  = {1'b0, cu_op1} - {1'b0, cu_op2};
    prod32 = 32'(cu_op1) * 32'(cu_op2);
    fl     = '0;
    res    = '0;
    case (cu_op)
      MUL: begin
        res      = prod32[15:0];
        fl.carry = |prod32[31:16];
      end
      SUB: begin
        res      = dif17[15:0];
        fl.carry = dif17[16];
        fl.ovf   = (cu_op1[15] != cu_op2[15]) && (res[15] != cu_op1[15]);
      end
      PASS: begin
        res = cu_op1;
      end
      default: begin
        res      = sum17[15:0];
        fl.carry = sum17[16];
        fl.ovf   = (cu_op1[15] == cu_op2[15]) && (res[15] != cu_op1[15]);
      end
    endcase
    fl.zero   = (res == 16'd0);
    fl.neg    = res[15];
    cu_result = cu_corrupt ? 16'hDEAD : res;
    cu_fls    = cu_corrupt ? flags_t'(4'b0101) : fl;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] a, input logic [15:0] b,
                         input operation_t op, input powermode_t pm);
    bus.req_op1   = a;
    bus.req_op2   = b;
    bus.req_op    = op;
    bus.req_pmode = pm;
    bus.req_valid = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
    check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    check({tag, "_rsp_fls"},    32'(bus.rsp_fls),    32'd0);
    check({tag, "_cu_op1"},     32'(cu_op1),         32'd0);
    check({tag, "_cu_op2"},     32'(cu_op2),         32'd0);
    check({tag, "_cu_op"},      32'(cu_op),          32'(ADD));
    check({tag, "_cu_pmode"},   32'(cu_pmode),       32'(NORMAL));
    check({tag, "_cu_sleep"},   32'(cu_sleep),       32'd0);
  endtask

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    flags_t sub_fls;
    sub_fls = '{carry: 1'b1, zero: 1'b0, neg: 1'b1, ovf: 1'b0};

    rst_n         = 1'b0;
    cu_corrupt    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_op    = ADD;
    bus.req_pmode = NORMAL;
    bus.rsp_ready = 1'b0;

    // Reset state
    #3;
    check_reset_values("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD NORMAL 2+4, L=1: capture at edge 1, consumed at edge 2
    bus.rsp_ready = 1'b1;
    present(16'd2, 16'd4, ADD, NORMAL);
    check("add_req_ready_idle", 32'(bus.req_ready), 32'd1);
    tick();                                   // edge 0: accept
    bus.req_valid = 1'b0;
    check("add_cu_op1", 32'(cu_op1), 32'd2);
    check("add_cu_op2", 32'(cu_op2), 32'd4);
    check("add_req_ready_busy", 32'(bus.req_ready), 32'd0);
    check("add_rsp_valid_e0", 32'(bus.rsp_valid), 32'd0);
    tick();                                   // edge 1: capture
    check("add_rsp_valid_e1", 32'(bus.rsp_valid), 32'd1);
    check("add_rsp_result", 32'(bus.rsp_result), 32'd6);
    check("add_rsp_fls", 32'(bus.rsp_fls), 32'd0);
    tick();                                   // edge 2: consumed
    check("add_rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
    check("add_req_ready_back", 32'(bus.req_ready), 32'd1);
    check("add_cu_op1_held", 32'(cu_op1), 32'd2);
    check("add_cu_op2_held", 32'(cu_op2), 32'd4);

    // MUL LP 2*5, L=4: capture at edge 4
    present(16'd2, 16'd5, MUL, LP);
    tick();                                   // edge 0
    bus.req_valid = 1'b0;
    check("mul_cu_op", 32'(cu_op), 32'(MUL));
    check("mul_cu_pmode", 32'(cu_pmode), 32'(LP));
    repeat (3) tick();                        // edges 1..3
    check("mul_rsp_valid_e3", 32'(bus.rsp_valid), 32'd0);
    tick();                                   // edge 4: capture
    check("mul_rsp_valid_e4", 32'(bus.rsp_valid), 32'd1);
    check("mul_rsp_result", 32'(bus.rsp_result), 32'd10);
    tick();                                   // edge 5: consumed
    check("mul_rsp_valid_done", 32'(bus.rsp_valid), 32'd0);

    // Backpressure: SUB NORMAL 3-5, held 6 cycles with the CU output spoiled
    bus.rsp_ready = 1'b0;
    present(16'd3, 16'd5, SUB, NORMAL);
    tick();                                   // edge 0
    bus.req_valid = 1'b0;
    tick();                                   // edge 1: capture
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_rsp_result", 32'(bus.rsp_result), 32'hFFFE);
    check("bp_rsp_fls", 32'(bus.rsp_fls), 32'(sub_fls));
    cu_corrupt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_hold_result", 32'(bus.rsp_result), 32'hFFFE);
      check("bp_hold_fls", 32'(bus.rsp_fls), 32'(sub_fls));
    end
    cu_corrupt    = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();                                   // consumed; now in IDLE
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);

    // Sleep entry: 15 idle edges awake, asleep after the 16th
    for (int i = 0; i < 15; i++) begin
      tick();
      check("sleep_pre", 32'(cu_sleep), 32'd0);
      check("idle_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    check("sleep_on", 32'(cu_sleep), 32'd1);
    repeat (4) tick();
    check("sleep_held", 32'(cu_sleep), 32'd1);
    check("sleep_cu_op1_frozen", 32'(cu_op1), 32'd3);

    // Wake: ADD NORMAL 3+3 from sleep, capture at edge L+1=2
    present(16'd3, 16'd3, ADD, NORMAL);
    tick();                                   // edge 0
    bus.req_valid = 1'b0;
    check("wake_sleep_cleared", 32'(cu_sleep), 32'd0);
    check("wake_req_ready", 32'(bus.req_ready), 32'd0);
    tick();                                   // edge 1: WAKE -> WAIT
    check("wake_rsp_valid_e1", 32'(bus.rsp_valid), 32'd0);
    tick();                                   // edge 2: capture
    check("wake_rsp_valid_e2", 32'(bus.rsp_valid), 32'd1);
    check("wake_rsp_result", 32'(bus.rsp_result), 32'd6);
    tick();                                   // edge 3: consumed
    check("wake_rsp_valid_done", 32'(bus.rsp_valid), 32'd0);

    // Reset mid-WAIT: MUL LP 7*7, reset asserted after edge 2
    present(16'd7, 16'd7, MUL, LP);
    tick();                                   // edge 0
    bus.req_valid = 1'b0;
    repeat (2) tick();                        // edges 1, 2
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    tick();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Back-to-back: ADD 1+1 then MUL 3*3 NORMAL (L=2), req_valid kept high
    present(16'd1, 16'd1, ADD, NORMAL);
    tick();                                   // edge 0: accept ADD
    present(16'd3, 16'd3, MUL, NORMAL);
    check("b2b_busy", 32'(bus.req_ready), 32'd0);
    tick();                                   // edge 1: capture ADD
    check("b2b_first_valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b_first_result", 32'(bus.rsp_result), 32'd2);
    check("b2b_first_cu_op1", 32'(cu_op1), 32'd1);
    tick();                                   // edge 2: consumed, one IDLE cycle
    check("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
    check("b2b_idle_valid", 32'(bus.rsp_valid), 32'd0);
    tick();                                   // edge 3: accept MUL
    bus.req_valid = 1'b0;
    check("b2b_second_ready", 32'(bus.req_ready), 32'd0);
    check("b2b_second_cu_op", 32'(cu_op), 32'(MUL));
    tick();                                   // edge 4
    check("b2b_second_valid_early", 32'(bus.rsp_valid), 32'd0);
    tick();                                   // edge 5: capture MUL
    check("b2b_second_valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b_second_result", 32'(bus.rsp_result), 32'd9);
    tick();                                   // edge 6: consumed
    check("b2b_second_done", 32'(bus.rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Request-side front end for the CU datapath. It accepts one operation at a time over a valid/ready request port, drives and holds the CU's operand, opcode and power-mode inputs, and waits a fixed, parameterised latency per (op, pmode) pair. It then captures `result` and `fls` and returns them over a valid/ready response port. The CU itself has no handshake, so this block owns all timing toward it; it also gates the CU into sleep after a programmable idle period.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must match CU.
- `LAT_ADD_NORMAL`, 1, CU cycles for ADD (and any non-MUL op) in NORMAL mode; legal range 1..15.
- `LAT_MUL_NORMAL`, 2, CU cycles for MUL in NORMAL mode.
- `LAT_ADD_LP`, 2, CU cycles for ADD (and any non-MUL op) in LP mode.
- `LAT_MUL_LP`, 4, CU cycles for MUL in LP mode.
- `IDLE_SLEEP`, 16, consecutive IDLE cycles before `cu_sleep` asserts; 0 disables sleep.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when both are high at a rising edge.
- `req_op1`, `req_op2`  in  WIDTH  operands.
- `req_op`  in  operation_t  opcode.
- `req_pmode`  in  powermode_t  power mode.
- `cu_op1`, `cu_op2`  out  WIDTH  to CU, registered.
- `cu_op`  out  operation_t  to CU, registered.
- `cu_pmode`  out  powermode_t  to CU, registered.
- `cu_sleep`  out  1  CU clock-gate/sleep request.
- `cu_result`  in  WIDTH  from CU.
- `cu_fls`  in  flags_t  from CU.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when both are high at a rising edge.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_fls`  out  flags_t  captured flags.

## Operation
- FSM states: IDLE, WAKE, WAIT, RESP.
- **IDLE**
  - `req_ready=1`.
  - On accept, latch operands, op and pmode into `cu_*`.
  - Load the latency counter with `L = lat(op, pmode)`.
  - If `cu_sleep=1` at the accept edge, go to WAKE; otherwise go to WAIT.
- **WAKE**
  - Lasts exactly one cycle.
  - `cu_sleep` is already 0.
  - Next state is WAIT.
- **WAIT**
  - Counter decrements each cycle.
  - On the edge where the counter reads 1, capture `cu_result` and `cu_fls` into the `rsp_*` registers and go to RESP.
- **RESP**
  - `rsp_valid=1`; `rsp_*` held stable.
  - On `rsp_ready`, go to IDLE.
  - `req_ready` stays 0; there is no overlap of request acceptance with the response.
- **Operand isolation**
  - `cu_*` change only on an accept edge.
  - `cu_*` hold their last value through IDLE and sleep, which gives zero toggle on the CU inputs.
- **Idle counter**
  - Increments each cycle in IDLE and saturates at `IDLE_SLEEP`.
  - Clears on leaving IDLE.
  - `cu_sleep` is registered. It is 1 when the counter equals `IDLE_SLEEP` and `IDLE_SLEEP != 0`.
  - `cu_sleep` clears on the accept edge.
- **Latency mapping**
  - `op==MUL` selects the MUL parameter for the current pmode.
  - Every other enumerator selects the ADD parameter.
- **Flags**: `flags_t` passes through opaque; the block never interprets it.
- **Reset**
  - Asynchronous and immediate, from any state including mid-WAIT or mid-RESP.
  - The in-flight operation is dropped silently; no response is generated.
  - Reset values:
    - FSM: IDLE.
    - `req_ready`: 1.
    - `rsp_valid`: 0.
    - `rsp_result`, `cu_op1`, `cu_op2`: 0.
    - `rsp_fls`: all zero.
    - `cu_op`: ADD.
    - `cu_pmode`: NORMAL.
    - `cu_sleep`: 0.
    - Both counters: 0.

## Timing
- The accept edge is edge 0.
- `cu_*` are valid after edge 0.
- Result capture:
  - Awake: capture at edge L.
  - Asleep at accept: capture at edge L+1.
- `rsp_valid` rises just after the capture edge.
- Request-to-response latency is L+1 cycles, or L+2 from sleep.
- Minimum cycles per operation is L+2; this includes the RESP handshake and one IDLE cycle.
- `req_ready` is combinational from state (`state==IDLE`). All other outputs are registered.
- If `req_valid` is already high when `rsp_ready` completes the handshake, the next accept occurs one cycle later, in IDLE.
- Requests presented outside IDLE are ignored. The requester must hold `req_valid` and the request data stable until accepted.

## Structure
- `operation_t`, `powermode_t` and `flags_t` come from the shared `ptype.svh` package.
- Add to that package:
  - the `cu_seq_state_t` enum;
  - a `cu_lat()` function mapping (op, pmode, parameters) to a latency.
- No sub-module is needed. The CU is instantiated alongside this block at the parent level, not inside it.

## Test plan
- **ADD, NORMAL, awake**: `op1=2`, `op2=4`. Expect `rsp_result=6` and `rsp_valid` high 2 cycles after accept; `cu_op1`/`cu_op2` held at 2/4 afterwards.
- **MUL, LP, awake**: `op1=2`, `op2=5`. Expect `rsp_result=10` and `rsp_valid` 5 cycles after accept.
- **Backpressure**: hold `rsp_ready=0` for 6 cycles after `rsp_valid`. Expect `rsp_result` and `rsp_fls` stable, `req_ready=0` throughout, and a single response on release.
- **Sleep entry and wake**: idle 20 cycles. Expect `cu_sleep=1` from the 16th IDLE cycle. Then ADD NORMAL 3+3 gives `cu_sleep=0` at accept and `rsp_result=6` 3 cycles after accept.
- **Reset mid-WAIT**: MUL LP accepted, then `rst_n` driven low at cycle 2. Expect immediate reset values on all outputs and no `rsp_valid` after `rst_n` returns high.
- **Back-to-back**: ADD 1+1 then MUL 3×3, with `req_valid` high continuously and `rsp_ready=1`. Expect responses 2 then 9, in order, with exactly one IDLE cycle between them.
